// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: diff = a - b, one bit per clock, LSB first.
// start/busy/done handshake; result registers hold until the next operation completes.
module serial_subtractor #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic         busy,
   output logic         done,
   output logic [W-1:0] diff,
   output logic         borrow,
   output logic         ovf,
   output logic         zero
);

   localparam int CW = $clog2(W + 1);
   localparam logic [CW-1:0] LAST = CW'(W - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [W-1:0]    sa_q, sa_d;
   logic [W-1:0]    sb_q, sb_d;
   logic [W-1:0]    acc_q, acc_d;
   logic            br_q, br_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            a_msb_q, a_msb_d;
   logic            b_msb_q, b_msb_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic [W-1:0]    diff_q, diff_d;
   logic            borrow_q, borrow_d;
   logic            ovf_q, ovf_d;
   logic            zero_q, zero_d;

   logic            bit_s;
   logic            br_next;
   logic [W-1:0]    acc_shift;

   always_comb begin
      state_d   = state_q;
      sa_d      = sa_q;
      sb_d      = sb_q;
      acc_d     = acc_q;
      br_d      = br_q;
      cnt_d     = cnt_q;
      a_msb_d   = a_msb_q;
      b_msb_d   = b_msb_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      diff_d    = diff_q;
      borrow_d  = borrow_q;
      ovf_d     = ovf_q;
      zero_d    = zero_q;

      bit_s     = sa_q[0] ^ sb_q[0] ^ br_q;
      br_next   = (~sa_q[0] & sb_q[0]) | (~(sa_q[0] ^ sb_q[0]) & br_q);
      acc_shift = {bit_s, acc_q[W-1:1]};

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = RUN;
               sa_d    = a;
               sb_d    = b;
               acc_d   = '0;
               br_d    = 1'b0;
               cnt_d   = '0;
               a_msb_d = a[W-1];
               b_msb_d = b[W-1];
               busy_d  = 1'b1;
            end
         end
         RUN: begin
            sa_d  = sa_q >> 1;
            sb_d  = sb_q >> 1;
            br_d  = br_next;
            acc_d = acc_shift;
            cnt_d = cnt_q + CW'(1);
            // Last bit-step: publish the completed accumulator together with its flags.
            if (cnt_q == LAST) begin
               state_d  = DONE;
               busy_d   = 1'b0;
               done_d   = 1'b1;
               diff_d   = acc_shift;
               borrow_d = br_next;
               ovf_d    = (a_msb_q ^ b_msb_q) & (acc_shift[W-1] ^ a_msb_q);
               zero_d   = (acc_shift == '0);
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         sa_q     <= '0;
         sb_q     <= '0;
         acc_q    <= '0;
         br_q     <= 1'b0;
         cnt_q    <= '0;
         a_msb_q  <= 1'b0;
         b_msb_q  <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         diff_q   <= '0;
         borrow_q <= 1'b0;
         ovf_q    <= 1'b0;
         zero_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         sa_q     <= sa_d;
         sb_q     <= sb_d;
         acc_q    <= acc_d;
         br_q     <= br_d;
         cnt_q    <= cnt_d;
         a_msb_q  <= a_msb_d;
         b_msb_q  <= b_msb_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         diff_q   <= diff_d;
         borrow_q <= borrow_d;
         ovf_q    <= ovf_d;
         zero_q   <= zero_d;
      end
   end

   assign busy   = busy_q;
   assign done   = done_q;
   assign diff   = diff_q;
   assign borrow = borrow_q;
   assign ovf    = ovf_q;
   assign zero   = zero_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor (W=8) plus an exhaustive W=4 sweep, queue scoreboard.
module tb_serial_subtractor;

   logic       clk = 1'b0;
   logic       rst = 1'b1;

   logic       start8 = 1'b0;
   logic [7:0] a8 = '0, b8 = '0;
   logic       busy8, done8, borrow8, ovf8, zero8;
   logic [7:0] diff8;

   logic       start4 = 1'b0;
   logic [3:0] a4 = '0, b4 = '0;
   logic       busy4, done4, borrow4, ovf4, zero4;
   logic [3:0] diff4;

   int vectors = 0;
   int miscompares = 0;

   typedef struct packed {
      logic [7:0] diff;
      logic       borrow;
      logic       ovf;
      logic       zero;
   } res8_t;

   res8_t      q8[$];
   logic [6:0] q4[$];

   always #5 clk = ~clk;

   serial_subtractor #(.W(8)) dut8 (
      .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
      .busy(busy8), .done(done8), .diff(diff8), .borrow(borrow8), .ovf(ovf8), .zero(zero8)
   );

   serial_subtractor #(.W(4)) dut4 (
      .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4),
      .busy(busy4), .done(done4), .diff(diff4), .borrow(borrow4), .ovf(ovf4), .zero(zero4)
   );

   function automatic res8_t model8(input logic [7:0] av, input logic [7:0] bv);
      res8_t r;
      logic [7:0] d;
      d        = av - bv;
      r.diff   = d;
      r.borrow = (av < bv);
      r.ovf    = (av[7] != bv[7]) && (d[7] != av[7]);
      r.zero   = (d == 8'h00);
      return r;
   endfunction

   function automatic logic [6:0] model4(input logic [3:0] av, input logic [3:0] bv);
      logic [3:0] d;
      d = av - bv;
      return {d, av < bv, (av[3] != bv[3]) && (d[3] != av[3]), d == 4'h0};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic pop8();
      res8_t e;
      check("sb8_nonempty", 32'(q8.size() != 0), 32'd1);
      if (q8.size() != 0) begin
         e = q8.pop_front();
         check("diff", 32'(diff8), 32'(e.diff));
         check("borrow", 32'(borrow8), 32'(e.borrow));
         check("ovf", 32'(ovf8), 32'(e.ovf));
         check("zero", 32'(zero8), 32'(e.zero));
      end
   endtask

   // pulse_at / rst_at: edge index T_n (n>0) at which start is re-pulsed / rst is asserted; 0 = none.
   task automatic run8(input logic [7:0] av, input logic [7:0] bv,
                       input int pulse_at, input bit pulse_done, input int rst_at);
      logic [10:0] prev;
      int k, busy_cnt, extra;
      bit got, both, stable;
      @(negedge clk);
      start8 = 1'b1; a8 = av; b8 = bv;
      if (rst_at == 0) q8.push_back(model8(av, bv));
      prev = {diff8, borrow8, ovf8, zero8};
      @(negedge clk);
      start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
      k = 0; busy_cnt = 0; got = 1'b0; both = 1'b0; stable = 1'b1;
      while (!got && k < 12) begin
         if (busy8) busy_cnt++;
         if (busy8 && done8) both = 1'b1;
         if ({diff8, borrow8, ovf8, zero8} != prev) stable = 1'b0;
         start8 = (k + 1 == pulse_at);
         if (start8) begin a8 = 8'hFF; b8 = 8'hFF; end
         rst = (k + 1 == rst_at);
         @(negedge clk);
         k++;
         start8 = 1'b0;
         if (rst_at != 0 && k == rst_at) break;
         if (done8) got = 1'b1;
      end
      if (rst_at != 0) begin
         rst = 1'b0;
         check("rst_busy", 32'(busy8), 32'd0);
         check("rst_done", 32'(done8), 32'd0);
         check("rst_diff", 32'(diff8), 32'd0);
         check("rst_borrow", 32'(borrow8), 32'd0);
         check("rst_ovf", 32'(ovf8), 32'd0);
         check("rst_zero", 32'(zero8), 32'd0);
      end else begin
         check("done_seen", 32'(got), 32'd1);
         check("latency", 32'(k), 32'd8);
         check("busy_cycles", 32'(busy_cnt), 32'd8);
         check("busy_done_overlap", 32'(both), 32'd0);
         check("result_hold", 32'(stable), 32'd1);
         check("busy_at_done", 32'(busy8), 32'd0);
         pop8();
      end
      if (pulse_done) begin start8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF; end
      @(negedge clk);
      start8 = 1'b0;
      check("done_drop", 32'(done8), 32'd0);
      check("idle_busy", 32'(busy8), 32'd0);
      if (pulse_done || pulse_at != 0 || rst_at != 0) begin
         extra = 0;
         repeat (10) begin
            @(negedge clk);
            if (done8 || busy8) extra++;
         end
         check("no_extra_activity", 32'(extra), 32'd0);
      end
   endtask

   initial begin
      logic [6:0] e4;
      int k;
      repeat (3) @(negedge clk);
      check("reset_busy", 32'(busy8), 32'd0);
      check("reset_done", 32'(done8), 32'd0);
      check("reset_diff", 32'(diff8), 32'd0);
      check("reset_flags", 32'({borrow8, ovf8, zero8}), 32'd0);
      check("reset_w4", 32'({busy4, done4, diff4, borrow4, ovf4, zero4}), 32'd0);
      rst = 1'b0;

      run8(8'h05, 8'h03, 0, 1'b0, 0);
      run8(8'h03, 8'h05, 0, 1'b0, 0);
      run8(8'h80, 8'h01, 0, 1'b0, 0);
      run8(8'h7F, 8'hFF, 0, 1'b0, 0);
      run8(8'h5A, 8'h5A, 0, 1'b0, 0);
      run8(8'h10, 8'h01, 3, 1'b1, 0);
      run8(8'h33, 8'h11, 0, 1'b0, 0);
      run8(8'h44, 8'h22, 0, 1'b0, 4);
      run8(8'h20, 8'h01, 0, 1'b0, 0);

      for (int i = 0; i < 256; i++) begin
         @(negedge clk);
         start4 = 1'b1; a4 = 4'(i >> 4); b4 = 4'(i);
         q4.push_back(model4(a4, b4));
         @(negedge clk);
         start4 = 1'b0;
         k = 0;
         while (!done4 && k < 10) begin
            @(negedge clk);
            k++;
         end
         check("w4_done_seen", 32'(done4), 32'd1);
         if (q4.size() != 0) begin
            e4 = q4.pop_front();
            check($sformatf("w4_a%0h_b%0h", i >> 4, i & 15),
                  32'({diff4, borrow4, ovf4, zero4}), 32'(e4));
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
